// File: rtl/ft_model_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ft_model_pkg
//  Brief    : Shared constants and width helpers for the FT sync-FIFO model.
//  Revision : 1.0  initial release
// ============================================================================
package ft_model_pkg;

    // Bit positions inside the sticky protocol-error vector
    localparam int ERR_RD_EMPTY = 0;
    localparam int ERR_WR_FULL  = 1;
    localparam int ERR_BUS_CONT = 2;
    localparam int ERR_W        = 3;

    // One byte-enable lane per byte, but the 8-bit bus still carries one BE pin
    function automatic int be_width(input int data_w);
        return (data_w / 8 > 1) ? (data_w / 8) : 1;
    endfunction

    // Occupancy counter must be able to hold the value DEPTH itself
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ft_sync_fifo_model_if.sv
`default_nettype none
// ============================================================================
//  Module   : ft_sync_fifo_model_if
//  Brief    : Host handshake, FT control pins, stall controls and status of the
//             FT sync-FIFO model. DATA/BE stay as module inout pins.
//  Revision : 1.0  initial release
// ============================================================================
interface ft_sync_fifo_model_if
    import ft_model_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int BE_W   = be_width(DATA_W)
) ();

    // FT control pins
    logic              RXF_N;
    logic              TXE_N;
    logic              RD_N;
    logic              WR_N;
    logic              OE_N;

    // Host RX push port
    logic              host_rx_valid;
    logic [DATA_W-1:0] host_rx_data;
    logic [BE_W-1:0]   host_rx_be;
    logic              host_rx_ready;

    // Host TX pop port
    logic              host_tx_valid;
    logic [DATA_W-1:0] host_tx_data;
    logic [BE_W-1:0]   host_tx_be;
    logic              host_tx_ready;

    // Flag stall injection and status
    logic              stall_rx;
    logic              stall_tx;
    logic [ERR_W-1:0]  proto_err;
    logic [15:0]       rx_words;
    logic [15:0]       tx_words;

    // Environment side: plays both the host and the DUT strobes
    modport master (
        input  RXF_N, TXE_N, host_rx_ready, host_tx_valid, host_tx_data,
               host_tx_be, proto_err, rx_words, tx_words,
        output RD_N, WR_N, OE_N, host_rx_valid, host_rx_data, host_rx_be,
               host_tx_ready, stall_rx, stall_tx
    );

    // Model side
    modport slave (
        output RXF_N, TXE_N, host_rx_ready, host_tx_valid, host_tx_data,
               host_tx_be, proto_err, rx_words, tx_words,
        input  RD_N, WR_N, OE_N, host_rx_valid, host_rx_data, host_rx_be,
               host_tx_ready, stall_rx, stall_tx
    );

endinterface
`default_nettype wire

// File: rtl/ft_model_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ft_model_fifo
//  Brief    : Single-clock FIFO with occupancy count and next-cycle count.
//             Caller guarantees no push when full and no pop when empty.
//  Revision : 1.0  initial release
// ============================================================================
module ft_model_fifo
    import ft_model_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int DEPTH = 16,
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer advance wraps naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset flushes the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head       = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule
`default_nettype wire

// File: rtl/ft_sync_fifo_model.sv
`default_nettype none
// ============================================================================
//  Module   : ft_sync_fifo_model
//  Brief    : Device-side model of an FTDI synchronous FIFO bridge. Host pushes
//             RX words / pops TX words; the model drives RXF_N/TXE_N/DATA/BE
//             toward the DUT and flags protocol violations.
//  Revision : 1.0  initial release
// ============================================================================
module ft_sync_fifo_model
    import ft_model_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int RX_DEPTH = 16,
    parameter  int TX_DEPTH = 16,
    localparam int BE_W     = be_width(DATA_W)
) (
    input  logic                ft_clk,
    input  logic                reset,
    ft_sync_fifo_model_if.slave bus,
    inout  wire  [DATA_W-1:0]   DATA,
    inout  wire  [BE_W-1:0]     BE
);

    localparam int RXC_W = cnt_width(RX_DEPTH);
    localparam int TXC_W = cnt_width(TX_DEPTH);
    localparam int FW    = DATA_W + BE_W;

    logic [FW-1:0]     rx_head;
    logic [FW-1:0]     tx_head;
    logic [RXC_W-1:0]  rx_count, rx_count_next;
    logic [TXC_W-1:0]  tx_count, tx_count_next;
    logic [DATA_W-1:0] rx_head_data;
    logic [BE_W-1:0]   rx_head_be;
    logic [BE_W-1:0]   be_out;
    logic [BE_W-1:0]   tx_be_in;
    logic              rx_push, rx_pop, tx_push, tx_pop;

    logic              drive_en_q, drive_en_d;
    logic              rxf_n_q, rxf_n_d;
    logic              txe_n_q, txe_n_d;
    logic [ERR_W-1:0]  proto_err_q, proto_err_d;
    logic [15:0]       rx_words_q, rx_words_d;
    logic [15:0]       tx_words_q, tx_words_d;

    // Transfer qualification against the registered flags and turnaround state
    assign rx_pop  = ~bus.RD_N & ~bus.OE_N & drive_en_q & ~rxf_n_q;
    assign tx_push = ~bus.WR_N & ~txe_n_q;
    assign rx_push = bus.host_rx_valid & bus.host_rx_ready;
    assign tx_pop  = bus.host_tx_valid & bus.host_tx_ready;

    ft_model_fifo #(.W(FW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk        (ft_clk),
        .rst        (reset),
        .push       (rx_push),
        .push_data  ({bus.host_rx_data, bus.host_rx_be}),
        .pop        (rx_pop),
        .head       (rx_head),
        .count      (rx_count),
        .count_next (rx_count_next)
    );

    ft_model_fifo #(.W(FW), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk        (ft_clk),
        .rst        (reset),
        .push       (tx_push),
        .push_data  ({DATA, tx_be_in}),
        .pop        (tx_pop),
        .head       (tx_head),
        .count      (tx_count),
        .count_next (tx_count_next)
    );

    assign rx_head_data = rx_head[FW-1:BE_W];
    assign rx_head_be   = rx_head[BE_W-1:0];

    // The 8-bit part has a single BE pin that reads as 1 and carries no write info
    generate
        if (DATA_W == 8) begin : g_be_narrow
            assign be_out   = rx_head_be | {BE_W{1'b1}};
            assign tx_be_in = BE | {BE_W{1'b1}};
        end else begin : g_be_wide
            assign be_out   = rx_head_be;
            assign tx_be_in = BE;
        end
    endgenerate

    // Next-state for flags, turnaround, sticky errors and word counters
    always_comb begin
        drive_en_d  = ~bus.OE_N;
        rxf_n_d     = bus.stall_rx | (rx_count_next == '0);
        txe_n_d     = bus.stall_tx | (tx_count_next == TXC_W'(TX_DEPTH));
        proto_err_d = proto_err_q;
        rx_words_d  = rx_words_q;
        tx_words_d  = tx_words_q;
        if (~bus.RD_N & ~bus.OE_N & (rxf_n_q | ~drive_en_q))
            proto_err_d[ERR_RD_EMPTY] = 1'b1;
        if (~bus.WR_N & txe_n_q)
            proto_err_d[ERR_WR_FULL] = 1'b1;
        if (~bus.WR_N & drive_en_q)
            proto_err_d[ERR_BUS_CONT] = 1'b1;
        if (rx_pop)  rx_words_d = rx_words_q + 16'd1;
        if (tx_push) tx_words_d = tx_words_q + 16'd1;
    end

    // State registers; reset releases the bus and raises both flags at once
    always_ff @(posedge ft_clk) begin
        if (reset) begin
            drive_en_q  <= 1'b0;
            rxf_n_q     <= 1'b1;
            txe_n_q     <= 1'b1;
            proto_err_q <= '0;
            rx_words_q  <= '0;
            tx_words_q  <= '0;
        end else begin
            drive_en_q  <= drive_en_d;
            rxf_n_q     <= rxf_n_d;
            txe_n_q     <= txe_n_d;
            proto_err_q <= proto_err_d;
            rx_words_q  <= rx_words_d;
            tx_words_q  <= tx_words_d;
        end
    end

    assign DATA = drive_en_q ? rx_head_data : {DATA_W{1'bz}};
    assign BE   = drive_en_q ? be_out       : {BE_W{1'bz}};

    assign bus.RXF_N         = rxf_n_q;
    assign bus.TXE_N         = txe_n_q;
    assign bus.host_rx_ready = (rx_count < RXC_W'(RX_DEPTH));
    assign bus.host_tx_valid = (tx_count != '0);
    assign bus.host_tx_data  = tx_head[FW-1:BE_W];
    assign bus.host_tx_be    = tx_head[BE_W-1:0];
    assign bus.proto_err     = proto_err_q;
    assign bus.rx_words      = rx_words_q;
    assign bus.tx_words      = tx_words_q;

endmodule
`default_nettype wire

// File: tb/tb_ft_sync_fifo_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ft_sync_fifo_model
//  Brief    : Directed bench for the 32-bit FT sync-FIFO model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ft_sync_fifo_model;

    logic        ft_clk = 1'b0;
    logic        reset;
    logic        drv_en;
    logic [31:0] drv_data;
    logic [3:0]  drv_be;
    wire  [31:0] DATA;
    wire  [3:0]  BE;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] rx_vec [4];

    ft_sync_fifo_model_if #(.DATA_W(32)) bus ();

    ft_sync_fifo_model #(.DATA_W(32), .RX_DEPTH(16), .TX_DEPTH(16)) dut (
        .ft_clk (ft_clk),
        .reset  (reset),
        .bus    (bus),
        .DATA   (DATA),
        .BE     (BE)
    );

    assign DATA = drv_en ? drv_data : 32'bz;
    assign BE   = drv_en ? drv_be   : 4'bz;

    always #5 ft_clk = ~ft_clk;

    task automatic tick();
        @(posedge ft_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_rx(input logic [31:0] d);
        bus.host_rx_valid = 1'b1;
        bus.host_rx_data  = d;
        bus.host_rx_be    = 4'hF;
        tick();
        bus.host_rx_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drv_en = 1'b0; drv_data = '0; drv_be = '0;
        bus.RD_N = 1'b1; bus.WR_N = 1'b1; bus.OE_N = 1'b1;
        bus.host_rx_valid = 1'b0; bus.host_rx_data = '0; bus.host_rx_be = '0;
        bus.host_tx_ready = 1'b0; bus.stall_rx = 1'b0; bus.stall_tx = 1'b0;
        rx_vec[0] = 32'h02; rx_vec[1] = 32'h04; rx_vec[2] = 32'h00; rx_vec[3] = 32'h11;
        tick(); tick();

        // Reset state
        chk("rst_rxf", bus.RXF_N, 1);
        chk("rst_txe", bus.TXE_N, 1);
        chk("rst_err", bus.proto_err, 0);
        chk("rst_rxw", bus.rx_words, 0);
        chk("rst_txw", bus.tx_words, 0);
        chk("rst_txv", bus.host_tx_valid, 0);
        chk("rst_rxr", bus.host_rx_ready, 1);
        reset = 1'b0;
        tick();
        chk("txe_after_rst", bus.TXE_N, 0);
        chk("rxf_after_rst", bus.RXF_N, 1);

        // Four-word RX burst
        for (int i = 0; i < 4; i++) push_rx(rx_vec[i]);
        chk("rxf_loaded", bus.RXF_N, 0);
        bus.OE_N = 1'b0;
        tick();
        chk("rd_be", BE, 4'hF);
        bus.RD_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rd_data", DATA, rx_vec[i]);
            tick();
            chk("rd_rxf", bus.RXF_N, (i == 3) ? 1 : 0);
        end
        bus.RD_N = 1'b1; bus.OE_N = 1'b1;
        tick();
        chk("rd_words", bus.rx_words, 4);
        chk("rd_err", bus.proto_err, 0);

        // 32-bit write with partial byte enables
        drv_en = 1'b1; drv_data = 32'hDEADBEEF; drv_be = 4'b0011; bus.WR_N = 1'b0;
        tick();
        bus.WR_N = 1'b1; drv_en = 1'b0;
        chk("wr_valid", bus.host_tx_valid, 1);
        chk("wr_data", bus.host_tx_data, 32'hDEADBEEF);
        chk("wr_be", bus.host_tx_be, 4'b0011);
        chk("wr_words", bus.tx_words, 1);
        bus.host_tx_ready = 1'b1;
        tick();
        bus.host_tx_ready = 1'b0;
        chk("wr_popped", bus.host_tx_valid, 0);

        // TX overflow: 20 write cycles into a 16-deep FIFO with no host pops
        drv_en = 1'b1; drv_be = 4'hF; bus.WR_N = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drv_data = 32'(i);
            tick();
            if (i == 14) chk("fill_txe15", bus.TXE_N, 0);
            if (i == 15) chk("fill_txe16", bus.TXE_N, 1);
        end
        bus.WR_N = 1'b1; drv_en = 1'b0;
        chk("fill_words", bus.tx_words, 17);
        chk("fill_err", bus.proto_err, 3'b010);
        chk("fill_txe", bus.TXE_N, 1);
        bus.host_tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", bus.host_tx_data, 32'(i));
            tick();
        end
        bus.host_tx_ready = 1'b0;
        chk("drain_valid", bus.host_tx_valid, 0);
        chk("drain_txe", bus.TXE_N, 0);

        // Read on the same edge OE_N first drops, then a stalled burst
        for (int i = 0; i < 8; i++) push_rx(32'h100 + 32'(i));
        bus.OE_N = 1'b0; bus.RD_N = 1'b0;
        tick();
        chk("early_err", bus.proto_err, 3'b011);
        chk("early_words", bus.rx_words, 4);
        for (int k = 0; k < 3; k++) begin
            chk("burst_data", DATA, 32'h100 + 32'(k));
            tick();
        end
        bus.stall_rx = 1'b1;
        chk("stall_edge_data", DATA, 32'h103);
        tick();
        chk("stall_rxf", bus.RXF_N, 1);
        bus.stall_rx = 1'b0; bus.RD_N = 1'b1;
        tick();
        chk("resume_rxf", bus.RXF_N, 0);
        chk("resume_data", DATA, 32'h104);
        chk("resume_words", bus.rx_words, 8);
        bus.RD_N = 1'b0;
        for (int k = 4; k < 8; k++) begin
            chk("resume_burst", DATA, 32'h100 + 32'(k));
            tick();
        end
        chk("burst_end_rxf", bus.RXF_N, 1);
        bus.RD_N = 1'b1;
        chk("burst_words", bus.rx_words, 12);

        // Write while the model drives the bus
        tick();
        bus.WR_N = 1'b0;
        tick();
        bus.WR_N = 1'b1; bus.OE_N = 1'b1;
        chk("cont_err", bus.proto_err, 3'b111);
        chk("cont_words", bus.tx_words, 18);
        tick();

        // Reset in the middle of an 8-word read burst
        for (int i = 0; i < 8; i++) push_rx(32'h200 + 32'(i));
        bus.OE_N = 1'b0;
        tick();
        bus.RD_N = 1'b0;
        tick(); tick();
        chk("mid_words", bus.rx_words, 14);
        reset = 1'b1;
        tick();
        chk("mrst_rxf", bus.RXF_N, 1);
        chk("mrst_txe", bus.TXE_N, 1);
        chk("mrst_err", bus.proto_err, 0);
        chk("mrst_rxw", bus.rx_words, 0);
        chk("mrst_txw", bus.tx_words, 0);
        chk("mrst_txv", bus.host_tx_valid, 0);
        chk("mrst_rxr", bus.host_rx_ready, 1);
        bus.RD_N = 1'b1; bus.OE_N = 1'b1; reset = 1'b0;
        tick();
        chk("post_rxf", bus.RXF_N, 1);
        chk("post_txe", bus.TXE_N, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
